// File: rtl/registro_sesgo_nc_pkg.sv
// Shared defaults and helpers for the mesh-edge skew register.
// lane_stages() is the single place that defines how deep each lane is.
package registro_sesgo_nc_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_BASE_DELAY = 1;

    function automatic int lane_stages(input int base_delay, input int lane);
        return base_delay + lane;
    endfunction

endpackage

// File: rtl/registro_sesgo_nc_if.sv
// Lane bundle between the operand memories (master) and the skew register (slave).
// Lanes are packed so that lane i occupies bits [i*WIDTH +: WIDTH].
interface registro_sesgo_nc_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    logic                               en;
    logic                               clr;
    logic [CHANNELS-1:0]                valid_in;
    logic [CHANNELS-1:0][WIDTH-1:0]     d;
    logic [CHANNELS-1:0][WIDTH-1:0]     q;
    logic [CHANNELS-1:0]                valid_out;
    logic                               busy;

    modport master (output en, clr, valid_in, d, input q, valid_out, busy);
    modport slave  (input en, clr, valid_in, d, output q, valid_out, busy);
endinterface

// File: rtl/registro_nb.sv
// One pipeline stage: async active-low reset, synchronous clear, hold when not enabled.
module registro_nb #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_d, q_q;

    // Clear wins over enable so a flush never lets a stalled word survive.
    always_comb begin
        q_d = q_q;
        if (clr_i)     q_d = '0;
        else if (en_i) q_d = d_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_q <= '0;
        else         q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/registro_sesgo_nc.sv
// N-lane skew register: lane i delays its word by BASE_DELAY+i enabled cycles,
// forming the diagonal wavefront fed into the systolic mesh edge.
module registro_sesgo_nc
    import registro_sesgo_nc_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int BASE_DELAY = DEF_BASE_DELAY
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    registro_sesgo_nc_if.slave   bus
);
    logic [CHANNELS-1:0][WIDTH-1:0] q_lane;
    logic [CHANNELS-1:0]            vout_lane;
    logic [CHANNELS-1:0]            busy_lane;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam int NS = lane_stages(BASE_DELAY, i);

        logic             cap_v;
        logic [WIDTH-1:0] cap;

        // Invalid words enter as zero padding so the mesh sees clean bubbles.
        assign cap_v = bus.valid_in[i];
        assign cap   = cap_v ? bus.d[i] : '0;

        if (NS == 0) begin : g_comb
            assign q_lane[i]    = cap;
            assign vout_lane[i] = cap_v;
            assign busy_lane[i] = 1'b0;
        end else begin : g_pipe
            logic [NS:0][WIDTH-1:0] dat;
            logic [NS:0]            vld_pipe;

            assign dat[0]      = cap;
            assign vld_pipe[0] = cap_v;

            for (genvar k = 1; k <= NS; k++) begin : g_stg
                registro_nb #(.WIDTH(WIDTH)) u_dat (
                    .clk_i (clk_i),
                    .rst_ni(rst_ni),
                    .en_i  (bus.en),
                    .clr_i (bus.clr),
                    .d_i   (dat[k-1]),
                    .q_o   (dat[k])
                );
                registro_nb #(.WIDTH(1)) u_vld (
                    .clk_i (clk_i),
                    .rst_ni(rst_ni),
                    .en_i  (bus.en),
                    .clr_i (bus.clr),
                    .d_i   (vld_pipe[k-1]),
                    .q_o   (vld_pipe[k])
                );
            end

            assign q_lane[i]    = dat[NS];
            assign vout_lane[i] = vld_pipe[NS];
            assign busy_lane[i] = |vld_pipe[NS:1];
        end
    end

    assign bus.q         = q_lane;
    assign bus.valid_out = vout_lane;
    assign bus.busy      = |busy_lane;
endmodule

// File: tb/tb_registro_sesgo_nc.sv
// Scoreboard bench: two instances (4 lanes/base 1 and 2 lanes/base 0) driven in
// lockstep, checked against a queue-per-lane delay-line model.
module tb_registro_sesgo_nc;

    localparam int BA = 1;
    localparam int BB = 0;

    typedef struct packed { logic v; logic [3:0] d; } word_t;
    typedef struct packed { logic [3:0][3:0] q; logic [3:0] v; logic b; } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0, clr = 1'b0;
    logic [3:0]       vin = '0;
    logic [3:0][3:0]  d = '0;

    int n_tests = 0;
    int n_fail  = 0;

    word_t pipe [2][4][$];
    exp_t  expq [2][$];

    always #5 clk = ~clk;

    registro_sesgo_nc_if #(.WIDTH(4), .CHANNELS(4)) ifa ();
    registro_sesgo_nc_if #(.WIDTH(4), .CHANNELS(2)) ifb ();

    assign ifa.en = en;  assign ifa.clr = clr;  assign ifa.valid_in = vin;      assign ifa.d = d;
    assign ifb.en = en;  assign ifb.clr = clr;  assign ifb.valid_in = vin[1:0]; assign ifb.d = d[1:0];

    registro_sesgo_nc #(.WIDTH(4), .CHANNELS(4), .BASE_DELAY(BA)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    registro_sesgo_nc #(.WIDTH(4), .CHANNELS(2), .BASE_DELAY(BB)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    function automatic int nch(input int inst);
        return (inst == 0) ? 4 : 2;
    endfunction

    function automatic int ndel(input int inst, input int l);
        return ((inst == 0) ? BA : BB) + l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        word_t z;
        z = '0;
        for (int i = 0; i < 2; i++)
            for (int l = 0; l < nch(i); l++) begin
                pipe[i][l].delete();
                repeat (ndel(i, l)) pipe[i][l].push_back(z);
            end
    endtask

    task automatic model_edge();
        word_t w;
        for (int i = 0; i < 2; i++)
            for (int l = 0; l < nch(i); l++) begin
                if (ndel(i, l) == 0) continue;
                if (clr) begin
                    w = '0;
                    pipe[i][l].delete();
                    repeat (ndel(i, l)) pipe[i][l].push_back(w);
                end else if (en) begin
                    w.v = vin[l];
                    w.d = vin[l] ? d[l] : 4'h0;
                    pipe[i][l].push_back(w);
                    w = pipe[i][l].pop_front();
                end
            end
    endtask

    function automatic exp_t model_out(input int inst);
        exp_t r;
        r = '0;
        for (int l = 0; l < nch(inst); l++) begin
            if (ndel(inst, l) == 0) begin
                r.v[l] = vin[l];
                r.q[l] = vin[l] ? d[l] : 4'h0;
            end else begin
                r.v[l] = pipe[inst][l][0].v;
                r.q[l] = pipe[inst][l][0].d;
                foreach (pipe[inst][l][k]) if (pipe[inst][l][k].v) r.b = 1'b1;
            end
        end
        return r;
    endfunction

    // Inputs are applied, one edge passes, expectations are queued; outputs settle by +2.
    task automatic step(input logic e, input logic c, input logic [3:0] v, input logic [15:0] dd);
        en = e; clr = c; vin = v; d = dd;
        @(posedge clk);
        model_edge();
        expq[0].push_back(model_out(0));
        expq[1].push_back(model_out(1));
        #4;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (expq[0].size() > 0) begin
                e = expq[0].pop_front();
                chk("A.q",    32'(ifa.q),         32'(e.q));
                chk("A.vout", 32'(ifa.valid_out), 32'(e.v));
                chk("A.busy", 32'(ifa.busy),      32'(e.b));
            end
            while (expq[1].size() > 0) begin
                e = expq[1].pop_front();
                chk("B.q",    32'(ifb.q),         32'(e.q[1:0]));
                chk("B.vout", 32'(ifb.valid_out), 32'(e.v[1:0]));
                chk("B.busy", 32'(ifb.busy),      32'(e.b));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        chk("rst.A.q",    32'(ifa.q),         32'h0);
        chk("rst.A.busy", 32'(ifa.busy),      32'h0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #4;

        // Skew: one full-width word, then bubbles.
        step(1, 0, 4'hF, 16'hDCBA);
        chk("skew.l0", {ifa.valid_out, ifa.q[0]}, {4'b0001, 4'hA});
        step(1, 0, 4'h0, 16'h0);
        chk("skew.l1", {ifa.valid_out, ifa.q[1]}, {4'b0010, 4'hB});
        step(1, 0, 4'h0, 16'h0);
        step(1, 0, 4'h0, 16'h0);
        chk("skew.l3", {ifa.valid_out, ifa.q[3], 3'b0, ifa.busy}, {4'b1000, 4'hD, 3'b0, 1'b1});
        step(1, 0, 4'h0, 16'h0);
        chk("skew.busy_fall", 32'(ifa.busy), 32'h0);

        // Stall for two cycles with junk on the inputs.
        step(1, 0, 4'hF, 16'hDCBA);
        step(1, 0, 4'h0, 16'h0);
        step(0, 0, 4'hF, 16'h9999);
        step(0, 0, 4'hF, 16'h9999);
        step(1, 0, 4'h0, 16'h0);
        chk("stall.l2", {ifa.valid_out[2], ifa.q[2]}, {1'b1, 4'hC});
        step(1, 0, 4'h0, 16'h0);
        chk("stall.l3", {ifa.valid_out[3], ifa.q[3]}, {1'b1, 4'hD});
        repeat (2) step(1, 0, 4'h0, 16'h0);

        // Flush with EN low.
        step(1, 0, 4'hF, 16'h5555);
        step(1, 0, 4'hF, 16'h5555);
        step(0, 1, 4'hF, 16'h5555);
        chk("flush", {ifa.q, ifa.valid_out, 3'b0, ifa.busy}, 24'h0);
        chk("flush.B1", {ifb.valid_out[1], ifb.q[1]}, 5'h0);

        // Padding: lanes 1 and 3 invalid.
        step(1, 0, 4'b0101, 16'hFFFF);
        chk("pad.l0", {ifa.valid_out[0], ifa.q[0]}, {1'b1, 4'hF});
        step(1, 0, 4'h0, 16'h0);
        chk("pad.l1", {ifa.valid_out[1], ifa.q[1]}, 5'h0);
        step(1, 0, 4'h0, 16'h0);
        chk("pad.l2", {ifa.valid_out[2], ifa.q[2]}, {1'b1, 4'hF});
        step(1, 0, 4'h0, 16'h0);
        chk("pad.l3", {ifa.valid_out[3], ifa.q[3]}, 5'h0);

        // Async reset mid-cycle with a full pipeline.
        repeat (4) step(1, 0, 4'hF, 16'(32'($urandom)) | 16'h1111);
        rst_n = 1'b0;
        vin = 4'h1; d = 16'h0007;
        #1;
        chk("arst.A", {ifa.q, ifa.valid_out, 3'b0, ifa.busy}, 24'h0);
        chk("arst.B1", {ifb.valid_out[1], ifb.q[1], 2'b0, ifb.busy}, 8'h0);
        chk("arst.B0comb", {ifb.valid_out[0], ifb.q[0]}, {1'b1, 4'h7});
        @(posedge clk); #2;
        chk("arst.hold", {ifa.q, ifa.valid_out, 3'b0, ifa.busy}, 24'h0);
        rst_n = 1'b1;
        model_reset();
        #2;
        repeat (3) step(1, 0, 4'h0, 16'h0);

        // Randomized traffic with stalls and occasional flushes.
        for (int n = 0; n < 400; n++)
            step(($urandom % 4) != 0, ($urandom % 20) == 0,
                 4'($urandom), 16'($urandom));

        @(posedge clk); #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
